// File: rtl/axioma_nvm_pkg.sv
// Shared definitions for the AxiomaCore-328 program-memory controller:
// command encodings, FSM state codes and small constant helpers.
package axioma_nvm_pkg;

  typedef enum logic [1:0] {
    OP_LOAD  = 2'b00,
    OP_ERASE = 2'b01,
    OP_WRITE = 2'b10,
    OP_CLEAR = 2'b11
  } nvm_op_e;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ERASE = 2'd1;
  localparam logic [1:0] ST_WRITE = 2'd2;

  localparam int unsigned MAX_DATA_W = 64;

  // Erased flash reads as all-ones for any word width up to MAX_DATA_W.
  function automatic logic [MAX_DATA_W-1:0] nvm_erased(input int unsigned width);
    if (width >= MAX_DATA_W) begin
      return '1;
    end
    return (64'd1 << width) - 64'd1;
  endfunction

  function automatic int unsigned nvm_max(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/axioma_nvm_page_buf.sv
// Page buffer for flash programming: one word register and one loaded flag
// per page offset, exposed in parallel for the whole-page write.
module axioma_nvm_page_buf
  import axioma_nvm_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int PAGE_W = 6
) (
  input  logic                                 clk,
  input  logic                                 reset_n,
  input  logic                                 load,
  input  logic [PAGE_W-1:0]                    load_off,
  input  logic [DATA_W-1:0]                    load_data,
  input  logic                                 clear,
  output logic [(1<<PAGE_W)-1:0][DATA_W-1:0]   buf_data,
  output logic                                 mask_any
);

  localparam int PAGE_WORDS = 1 << PAGE_W;
  localparam logic [DATA_W-1:0] ERASED = DATA_W'(nvm_erased(DATA_W));

  logic [PAGE_WORDS-1:0] mask_vec;

  genvar gi;
  generate
    for (gi = 0; gi < PAGE_WORDS; gi++) begin : g_word
      logic [DATA_W-1:0] word_reg;
      logic              loaded_reg;

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          word_reg   <= ERASED;
          loaded_reg <= 1'b0;
        end else if (clear) begin
          word_reg   <= ERASED;
          loaded_reg <= 1'b0;
        end else if (load && (load_off == PAGE_W'(gi))) begin
          word_reg   <= load_data;
          loaded_reg <= 1'b1;
        end
      end

      assign buf_data[gi] = word_reg;
      assign mask_vec[gi] = loaded_reg;
    end
  endgenerate

  assign mask_any = |mask_vec;

endmodule

// File: rtl/axioma_nvm_ctrl.sv
// AxiomaCore-328 program-memory controller: pipelined CPU read port plus a
// load/erase/write/clear command port over a behavioural flash array.
module axioma_nvm_ctrl
  import axioma_nvm_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 14,
  parameter int PAGE_W     = 6,
  parameter int BOOT_WORDS = 512,
  parameter int READ_LAT   = 1,
  parameter int ERASE_CYC  = 16,
  parameter int WRITE_CYC  = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_data,
  input  logic              boot_unlock,
  output logic              busy,
  output logic              done,
  output logic              err_prot,
  output logic              err_nobuf
);

  localparam int DEPTH      = 1 << ADDR_W;
  localparam int PAGE_WORDS = 1 << PAGE_W;
  localparam int PG_W       = ADDR_W - PAGE_W;
  localparam int CNT_W      = $clog2(nvm_max(ERASE_CYC, WRITE_CYC) + 1);
  localparam logic [PG_W:0] PROT_PAGE = (PG_W+1)'((DEPTH - BOOT_WORDS) >> PAGE_W);

  logic [1:0]       state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [PG_W-1:0]  page_reg;
  logic             done_reg;
  logic             err_prot_reg;
  logic             err_nobuf_reg;

  // The array holds complemented words so that an all-zero power-up image
  // reads back as erased (all-ones) flash.
  logic [DATA_W-1:0] mem_reg [DEPTH];

  logic [PAGE_WORDS-1:0][DATA_W-1:0] pb_data;
  logic                              pb_any;

  nvm_op_e         op;
  logic [PG_W-1:0] cmd_page;
  logic            idle;
  logic            cmd_fire;
  logic            rd_fire;
  logic            is_prog;
  logic            prot_hit;
  logic            start_erase;
  logic            start_write;
  logic            rej_prot;
  logic            rej_nobuf;
  logic            op_last;
  logic            pb_load;
  logic            pb_clear;

  assign op       = nvm_op_e'(cmd_op);
  assign cmd_page = cmd_addr[ADDR_W-1:PAGE_W];
  assign idle     = (state_reg == ST_IDLE);
  assign cmd_fire = cmd_valid && idle;
  assign rd_fire  = rd_req && idle;

  assign is_prog     = (op == OP_ERASE) || (op == OP_WRITE);
  assign prot_hit    = ({1'b0, cmd_page} >= PROT_PAGE) && !boot_unlock;
  assign start_erase = cmd_fire && (op == OP_ERASE) && !prot_hit;
  assign start_write = cmd_fire && (op == OP_WRITE) && !prot_hit && pb_any;
  assign rej_prot    = cmd_fire && is_prog && prot_hit;
  assign rej_nobuf   = cmd_fire && (op == OP_WRITE) && !prot_hit && !pb_any;

  assign op_last  = !idle && (cnt_reg == CNT_W'(1));
  assign pb_load  = cmd_fire && (op == OP_LOAD);
  assign pb_clear = (cmd_fire && (op == OP_CLEAR)) || (op_last && (state_reg == ST_WRITE));

  axioma_nvm_page_buf #(
    .DATA_W (DATA_W),
    .PAGE_W (PAGE_W)
  ) u_page_buf (
    .clk       (clk),
    .reset_n   (reset_n),
    .load      (pb_load),
    .load_off  (cmd_addr[PAGE_W-1:0]),
    .load_data (cmd_data),
    .clear     (pb_clear),
    .buf_data  (pb_data),
    .mask_any  (pb_any)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= ST_IDLE;
      cnt_reg       <= '0;
      page_reg      <= '0;
      done_reg      <= 1'b0;
      err_prot_reg  <= 1'b0;
      err_nobuf_reg <= 1'b0;
    end else begin
      done_reg      <= op_last;
      err_prot_reg  <= rej_prot;
      err_nobuf_reg <= rej_nobuf;
      if (start_erase) begin
        state_reg <= ST_ERASE;
        cnt_reg   <= CNT_W'(ERASE_CYC);
        page_reg  <= cmd_page;
      end else if (start_write) begin
        state_reg <= ST_WRITE;
        cnt_reg   <= CNT_W'(WRITE_CYC);
        page_reg  <= cmd_page;
      end else if (op_last) begin
        state_reg <= ST_IDLE;
        cnt_reg   <= '0;
      end else if (!idle) begin
        cnt_reg <= cnt_reg - CNT_W'(1);
      end
    end
  end

  // Whole-page commit in the final busy cycle; an aborted operation never
  // reaches this point, so the array stays untouched. Stored form is
  // complemented, so clearing bits (old & buf) becomes stored | ~buf.
  always_ff @(posedge clk) begin
    if (op_last) begin
      for (int i = 0; i < PAGE_WORDS; i++) begin
        if (state_reg == ST_ERASE) begin
          mem_reg[{page_reg, PAGE_W'(i)}] <= '0;
        end else begin
          mem_reg[{page_reg, PAGE_W'(i)}] <= mem_reg[{page_reg, PAGE_W'(i)}] | ~pb_data[i];
        end
      end
    end
  end

  logic [DATA_W-1:0] rd_data_reg  [READ_LAT];
  logic              rd_valid_reg [READ_LAT];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int s = 0; s < READ_LAT; s++) begin
        rd_data_reg[s]  <= '0;
        rd_valid_reg[s] <= 1'b0;
      end
    end else begin
      rd_valid_reg[0] <= rd_fire;
      if (rd_fire) begin
        rd_data_reg[0] <= ~mem_reg[rd_addr];
      end
      for (int s = 1; s < READ_LAT; s++) begin
        rd_valid_reg[s] <= rd_valid_reg[s-1];
        rd_data_reg[s]  <= rd_data_reg[s-1];
      end
    end
  end

  assign rd_ready  = idle;
  assign cmd_ready = idle;
  assign rd_data   = rd_data_reg[READ_LAT-1];
  assign rd_valid  = rd_valid_reg[READ_LAT-1];
  assign busy      = !idle;
  assign done      = done_reg;
  assign err_prot  = err_prot_reg;
  assign err_nobuf = err_nobuf_reg;

endmodule

// File: tb/tb_axioma_nvm_ctrl.sv
// Self-checking bench for axioma_nvm_ctrl: directed scenarios plus randomized
// commands compared against a word-array/page-buffer reference model.
module tb_axioma_nvm_ctrl;
  import axioma_nvm_pkg::*;

  localparam int DATA_W     = 16;
  localparam int ADDR_W     = 14;
  localparam int PAGE_W     = 6;
  localparam int BOOT_WORDS = 512;
  localparam int READ_LAT   = 1;
  localparam int ERASE_CYC  = 16;
  localparam int WRITE_CYC  = 32;
  localparam int DEPTH      = 1 << ADDR_W;
  localparam int PAGE_WORDS = 1 << PAGE_W;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              rd_req = 1'b0;
  logic [ADDR_W-1:0] rd_addr = '0;
  logic              rd_ready;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic [1:0]        cmd_op = 2'b00;
  logic [ADDR_W-1:0] cmd_addr = '0;
  logic [DATA_W-1:0] cmd_data = '0;
  logic              boot_unlock = 1'b0;
  logic              busy;
  logic              done;
  logic              err_prot;
  logic              err_nobuf;

  int checks = 0;
  int failures = 0;

  logic [DATA_W-1:0] model_mem  [DEPTH];
  logic [DATA_W-1:0] model_buf  [PAGE_WORDS];
  bit                model_mask [PAGE_WORDS];

  always #5 clk = ~clk;

  axioma_nvm_ctrl #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .PAGE_W(PAGE_W), .BOOT_WORDS(BOOT_WORDS),
    .READ_LAT(READ_LAT), .ERASE_CYC(ERASE_CYC), .WRITE_CYC(WRITE_CYC)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_ready(rd_ready), .rd_data(rd_data), .rd_valid(rd_valid),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_addr(cmd_addr),
    .cmd_data(cmd_data), .boot_unlock(boot_unlock),
    .busy(busy), .done(done), .err_prot(err_prot), .err_nobuf(err_nobuf)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear_buf();
    for (int i = 0; i < PAGE_WORDS; i++) begin
      model_buf[i]  = 16'hFFFF;
      model_mask[i] = 1'b0;
    end
  endtask

  // Reference behaviour of one accepted command, expressed on whole pages.
  task automatic model_cmd(input logic [1:0] op, input logic [ADDR_W-1:0] addr,
                           input logic [DATA_W-1:0] data, input bit unlock,
                           output bit e_prot, output bit e_nobuf, output int e_busy, output bit e_done);
    int  base;
    bit  any;
    base = (int'(addr) / PAGE_WORDS) * PAGE_WORDS;
    any = 1'b0;
    e_prot = 1'b0; e_nobuf = 1'b0; e_busy = 0; e_done = 1'b0;
    foreach (model_mask[i]) any |= model_mask[i];
    if (op == OP_LOAD) begin
      model_buf[int'(addr) % PAGE_WORDS]  = data;
      model_mask[int'(addr) % PAGE_WORDS] = 1'b1;
    end else if (op == OP_CLEAR) begin
      model_clear_buf();
    end else if (base >= DEPTH - BOOT_WORDS && !unlock) begin
      e_prot = 1'b1;
    end else if (op == OP_WRITE && !any) begin
      e_nobuf = 1'b1;
    end else begin
      e_done = 1'b1;
      e_busy = (op == OP_ERASE) ? ERASE_CYC : WRITE_CYC;
      for (int i = 0; i < PAGE_WORDS; i++) begin
        model_mem[base+i] = (op == OP_ERASE) ? 16'hFFFF : (model_mem[base+i] & model_buf[i]);
      end
      if (op == OP_WRITE) model_clear_buf();
    end
  endtask

  // Issue one command (optionally with a same-cycle read) and report what the DUT did.
  task automatic run_cmd(input logic [1:0] op, input logic [ADDR_W-1:0] addr,
                         input logic [DATA_W-1:0] data, input bit unlock,
                         input bit rd_en, input logic [ADDR_W-1:0] rd_a,
                         output bit o_prot, output bit o_nobuf, output int o_busy, output bit o_done,
                         output bit o_rv, output logic [DATA_W-1:0] o_rd);
    cmd_valid = 1'b1; cmd_op = op; cmd_addr = addr; cmd_data = data; boot_unlock = unlock;
    rd_req = rd_en; rd_addr = rd_a;
    tick();
    cmd_valid = 1'b0; boot_unlock = 1'b0; rd_req = 1'b0;
    o_prot = err_prot; o_nobuf = err_nobuf; o_rv = rd_valid; o_rd = rd_data;
    o_busy = 0;
    while (busy === 1'b1 && o_busy < 1000) begin
      o_busy++;
      tick();
    end
    o_done = done;
  endtask

  task automatic read_word(input logic [ADDR_W-1:0] a, output logic [DATA_W-1:0] d, output bit v);
    rd_req = 1'b1; rd_addr = a;
    tick();
    rd_req = 1'b0;
    repeat (READ_LAT - 1) tick();
    v = rd_valid; d = rd_data;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({rd_ready, cmd_ready, busy, done, err_prot, err_nobuf, rd_valid} !== 7'b1100000 || rd_data !== 16'h0000) begin
      failures++;
      $display("FAIL reset_outputs: got rdy/cready/busy/done/ep/en/rv=%b rd_data=%h expected 1100000 and 0000",
               {rd_ready, cmd_ready, busy, done, err_prot, err_nobuf, rd_valid}, rd_data);
    end
    reset_n = 1'b1;
    tick();
    $display("reset released: rd_ready=%b cmd_ready=%b", rd_ready, cmd_ready);
  endtask

  task automatic test_read_basic();
    logic [DATA_W-1:0] d;
    bit v;
    read_word(14'h0005, d, v);
    checks++;
    if (v !== 1'b1 || d !== model_mem[5]) begin
      failures++;
      $display("FAIL read_erased: got valid=%b data=%h expected valid=1 data=%h", v, d, model_mem[5]);
    end
    $display("read 0005 -> %h", d);
    rd_req = 1'b1; rd_addr = 14'h0000;
    tick();
    for (int i = 1; i <= 4; i++) begin
      checks++;
      if (rd_valid !== 1'b1 || rd_data !== model_mem[i-1]) begin
        failures++;
        $display("FAIL b2b_read[%0d]: got valid=%b data=%h expected valid=1 data=%h", i-1, rd_valid, rd_data, model_mem[i-1]);
      end
      $display("b2b read %0d -> %h", i-1, rd_data);
      if (i < 4) rd_addr = ADDR_W'(i);
      else rd_req = 1'b0;
      tick();
    end
    checks++;
    if (rd_valid !== 1'b0) begin
      failures++;
      $display("FAIL b2b_read_end: got valid=%b expected 0", rd_valid);
    end
  endtask

  task automatic test_write();
    bit e_p, e_n, e_d, o_p, o_n, o_d, rv;
    int e_b, o_b;
    logic [DATA_W-1:0] d;
    for (int i = 0; i < PAGE_WORDS; i++) begin
      model_cmd(OP_LOAD, ADDR_W'(i), 16'h1200 + 16'(i), 1'b0, e_p, e_n, e_b, e_d);
      run_cmd(OP_LOAD, ADDR_W'(i), 16'h1200 + 16'(i), 1'b0, 1'b0, '0, o_p, o_n, o_b, o_d, rv, d);
    end
    model_cmd(OP_WRITE, 14'h00C0, '0, 1'b0, e_p, e_n, e_b, e_d);
    run_cmd(OP_WRITE, 14'h00C0, '0, 1'b0, 1'b0, '0, o_p, o_n, o_b, o_d, rv, d);
    checks++;
    if ({o_p, o_n, o_d} !== {e_p, e_n, e_d} || o_b != e_b) begin
      failures++;
      $display("FAIL write_page3: got prot/nobuf/done=%b busy=%0d expected %b busy=%0d", {o_p, o_n, o_d}, o_b, {e_p, e_n, e_d}, e_b);
    end
    $display("write page 3: busy=%0d done=%b", o_b, o_d);
    read_word(14'h00C5, d, rv);
    checks++;
    if (rv !== 1'b1 || d !== model_mem[14'h00C5]) begin
      failures++;
      $display("FAIL read_00C5: got %h expected %h", d, model_mem[14'h00C5]);
    end
    model_cmd(OP_WRITE, 14'h00C0, '0, 1'b0, e_p, e_n, e_b, e_d);
    run_cmd(OP_WRITE, 14'h00C0, '0, 1'b0, 1'b0, '0, o_p, o_n, o_b, o_d, rv, d);
    checks++;
    if ({o_p, o_n, o_d} !== {e_p, e_n, e_d} || o_b != e_b) begin
      failures++;
      $display("FAIL write_nobuf: got prot/nobuf/done=%b busy=%0d expected %b busy=%0d", {o_p, o_n, o_d}, o_b, {e_p, e_n, e_d}, e_b);
    end
    $display("empty-buffer write: err_nobuf=%b", o_n);
  endtask

  task automatic test_partial_write();
    bit e_p, e_n, e_d, o_p, o_n, o_d, rv;
    int e_b, o_b;
    logic [DATA_W-1:0] d;
    model_cmd(OP_LOAD, 14'h0001, 16'h0F0F, 1'b0, e_p, e_n, e_b, e_d);
    run_cmd(OP_LOAD, 14'h0001, 16'h0F0F, 1'b0, 1'b0, '0, o_p, o_n, o_b, o_d, rv, d);
    model_cmd(OP_WRITE, 14'h00C0, '0, 1'b0, e_p, e_n, e_b, e_d);
    run_cmd(OP_WRITE, 14'h00C0, '0, 1'b0, 1'b0, '0, o_p, o_n, o_b, o_d, rv, d);
    checks++;
    if ({o_p, o_n, o_d} !== {e_p, e_n, e_d} || o_b != e_b) begin
      failures++;
      $display("FAIL partial_write: got prot/nobuf/done=%b busy=%0d expected %b busy=%0d", {o_p, o_n, o_d}, o_b, {e_p, e_n, e_d}, e_b);
    end
    for (int a = 'h00C1; a <= 'h00C2; a++) begin
      read_word(ADDR_W'(a), d, rv);
      checks++;
      if (rv !== 1'b1 || d !== model_mem[a]) begin
        failures++;
        $display("FAIL partial_read[%h]: got %h expected %h", a, d, model_mem[a]);
      end
      $display("partial write read %h -> %h", a, d);
    end
  endtask

  task automatic test_erase();
    bit e_p, e_n, e_d, o_p, o_n, o_d, rv;
    int e_b, o_b, bad;
    logic [DATA_W-1:0] d, pre;
    pre = model_mem[14'h00C0];
    model_cmd(OP_ERASE, 14'h00C0, '0, 1'b0, e_p, e_n, e_b, e_d);
    run_cmd(OP_ERASE, 14'h00C0, '0, 1'b0, 1'b1, 14'h00C0, o_p, o_n, o_b, o_d, rv, d);
    checks++;
    if (rv !== 1'b1 || d !== pre) begin
      failures++;
      $display("FAIL erase_same_cycle_read: got valid=%b data=%h expected valid=1 data=%h", rv, d, pre);
    end
    checks++;
    if ({o_p, o_n, o_d} !== {e_p, e_n, e_d} || o_b != e_b) begin
      failures++;
      $display("FAIL erase_page3: got prot/nobuf/done=%b busy=%0d expected %b busy=%0d", {o_p, o_n, o_d}, o_b, {e_p, e_n, e_d}, e_b);
    end
    $display("erase page 3: busy=%0d done=%b concurrent read=%h", o_b, o_d, d);
    bad = 0;
    for (int a = 'h00C0; a <= 'h00FF; a++) begin
      read_word(ADDR_W'(a), d, rv);
      if (rv !== 1'b1 || d !== model_mem[a]) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL erase_contents: got %0d words not erased expected 0", bad);
    end
  endtask

  task automatic test_protect();
    bit e_p, e_n, e_d, o_p, o_n, o_d, rv;
    int e_b, o_b;
    logic [DATA_W-1:0] d;
    model_cmd(OP_LOAD, 14'h0002, 16'h3C3C, 1'b0, e_p, e_n, e_b, e_d);
    run_cmd(OP_LOAD, 14'h0002, 16'h3C3C, 1'b0, 1'b0, '0, o_p, o_n, o_b, o_d, rv, d);
    model_cmd(OP_WRITE, 14'h3E00, '0, 1'b1, e_p, e_n, e_b, e_d);
    run_cmd(OP_WRITE, 14'h3E00, '0, 1'b1, 1'b0, '0, o_p, o_n, o_b, o_d, rv, d);
    checks++;
    if ({o_p, o_n, o_d} !== {e_p, e_n, e_d} || o_b != e_b) begin
      failures++;
      $display("FAIL unlocked_boot_write: got prot/nobuf/done=%b busy=%0d expected %b busy=%0d", {o_p, o_n, o_d}, o_b, {e_p, e_n, e_d}, e_b);
    end
    model_cmd(OP_ERASE, 14'h3E00, '0, 1'b0, e_p, e_n, e_b, e_d);
    run_cmd(OP_ERASE, 14'h3E00, '0, 1'b0, 1'b0, '0, o_p, o_n, o_b, o_d, rv, d);
    checks++;
    if ({o_p, o_n, o_d} !== {e_p, e_n, e_d} || o_b != e_b) begin
      failures++;
      $display("FAIL locked_boot_erase: got prot/nobuf/done=%b busy=%0d expected %b busy=%0d", {o_p, o_n, o_d}, o_b, {e_p, e_n, e_d}, e_b);
    end
    $display("locked erase page 248: err_prot=%b busy=%0d", o_p, o_b);
    read_word(14'h3E02, d, rv);
    checks++;
    if (rv !== 1'b1 || d !== model_mem[14'h3E02]) begin
      failures++;
      $display("FAIL boot_unchanged: got %h expected %h", d, model_mem[14'h3E02]);
    end
    // Empty buffer plus locked page: protection must win over the buffer check.
    model_cmd(OP_WRITE, 14'h3FC0, '0, 1'b0, e_p, e_n, e_b, e_d);
    run_cmd(OP_WRITE, 14'h3FC0, '0, 1'b0, 1'b0, '0, o_p, o_n, o_b, o_d, rv, d);
    checks++;
    if ({o_p, o_n, o_d} !== {e_p, e_n, e_d} || o_b != e_b) begin
      failures++;
      $display("FAIL prot_before_nobuf: got prot/nobuf/done=%b busy=%0d expected %b busy=%0d", {o_p, o_n, o_d}, o_b, {e_p, e_n, e_d}, e_b);
    end
    model_cmd(OP_ERASE, 14'h3E00, '0, 1'b1, e_p, e_n, e_b, e_d);
    run_cmd(OP_ERASE, 14'h3E00, '0, 1'b1, 1'b0, '0, o_p, o_n, o_b, o_d, rv, d);
    checks++;
    if ({o_p, o_n, o_d} !== {e_p, e_n, e_d} || o_b != e_b) begin
      failures++;
      $display("FAIL unlocked_boot_erase: got prot/nobuf/done=%b busy=%0d expected %b busy=%0d", {o_p, o_n, o_d}, o_b, {e_p, e_n, e_d}, e_b);
    end
    read_word(14'h3E02, d, rv);
    checks++;
    if (rv !== 1'b1 || d !== model_mem[14'h3E02]) begin
      failures++;
      $display("FAIL boot_erased: got %h expected %h", d, model_mem[14'h3E02]);
    end
    $display("unlocked erase page 248: busy=%0d word 3E02=%h", o_b, d);
  endtask

  task automatic test_busy_hold();
    bit e_p, e_n, e_d, o_p, o_n, o_d, rv;
    int e_b, o_b, n, viol;
    logic [DATA_W-1:0] d;
    model_cmd(OP_LOAD, 14'h0000, 16'h5A5A, 1'b0, e_p, e_n, e_b, e_d);
    run_cmd(OP_LOAD, 14'h0000, 16'h5A5A, 1'b0, 1'b0, '0, o_p, o_n, o_b, o_d, rv, d);
    model_cmd(OP_WRITE, 14'h01C0, '0, 1'b0, e_p, e_n, e_b, e_d);
    cmd_valid = 1'b1; cmd_op = OP_WRITE; cmd_addr = 14'h01C0;
    tick();
    cmd_op = OP_LOAD; cmd_addr = 14'h0003; cmd_data = 16'h00F0;
    n = 0; viol = 0;
    while (busy === 1'b1 && n < 1000) begin
      n++;
      if (cmd_ready !== 1'b0) viol++;
      tick();
    end
    o_d = done;
    tick();
    cmd_valid = 1'b0;
    checks++;
    if (n != e_b || o_d !== e_d || viol != 0) begin
      failures++;
      $display("FAIL busy_hold: got busy=%0d done=%b ready_violations=%0d expected busy=%0d done=%b 0", n, o_d, viol, e_b, e_d);
    end
    model_cmd(OP_LOAD, 14'h0003, 16'h00F0, 1'b0, e_p, e_n, e_b, e_d);
    model_cmd(OP_WRITE, 14'h0200, '0, 1'b0, e_p, e_n, e_b, e_d);
    run_cmd(OP_WRITE, 14'h0200, '0, 1'b0, 1'b0, '0, o_p, o_n, o_b, o_d, rv, d);
    checks++;
    if ({o_p, o_n, o_d} !== {e_p, e_n, e_d} || o_b != e_b) begin
      failures++;
      $display("FAIL held_load_write: got prot/nobuf/done=%b busy=%0d expected %b busy=%0d", {o_p, o_n, o_d}, o_b, {e_p, e_n, e_d}, e_b);
    end
    read_word(14'h0203, d, rv);
    checks++;
    if (rv !== 1'b1 || d !== model_mem[14'h0203]) begin
      failures++;
      $display("FAIL held_load_data: got %h expected %h", d, model_mem[14'h0203]);
    end
    $display("held LOAD after busy: word 0203=%h", d);
  endtask

  task automatic test_random();
    bit e_p, e_n, e_d, o_p, o_n, o_d, rv, unlock;
    int e_b, o_b, page, nload, r;
    logic [1:0] op;
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d, v;
    for (int it = 0; it < 30; it++) begin
      page   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(248, 255)) : int'($urandom_range(0, 247));
      nload  = $urandom_range(0, 6);
      unlock = 1'($urandom_range(0, 1));
      for (int k = 0; k < nload; k++) begin
        a = ADDR_W'($urandom_range(0, PAGE_WORDS - 1));
        v = DATA_W'($urandom);
        model_cmd(OP_LOAD, a, v, 1'b0, e_p, e_n, e_b, e_d);
        run_cmd(OP_LOAD, a, v, 1'b0, 1'b0, '0, o_p, o_n, o_b, o_d, rv, d);
      end
      r  = $urandom_range(0, 9);
      op = (r < 5) ? OP_WRITE : (r < 8) ? OP_ERASE : OP_CLEAR;
      a  = ADDR_W'(page * PAGE_WORDS);
      model_cmd(op, a, '0, unlock, e_p, e_n, e_b, e_d);
      run_cmd(op, a, '0, unlock, 1'b0, '0, o_p, o_n, o_b, o_d, rv, d);
      checks++;
      if ({o_p, o_n, o_d} !== {e_p, e_n, e_d} || o_b != e_b) begin
        failures++;
        $display("FAIL rand_cmd[%0d] op=%0d page=%0d: got prot/nobuf/done=%b busy=%0d expected %b busy=%0d",
                 it, op, page, {o_p, o_n, o_d}, o_b, {e_p, e_n, e_d}, e_b);
      end
      $display("rand %0d: op=%0d page=%0d unlock=%b prot=%b nobuf=%b busy=%0d", it, op, page, unlock, o_p, o_n, o_b);
      for (int k = 0; k < 3; k++) begin
        a = ADDR_W'(page * PAGE_WORDS + int'($urandom_range(0, PAGE_WORDS - 1)));
        read_word(a, d, rv);
        checks++;
        if (rv !== 1'b1 || d !== model_mem[a]) begin
          failures++;
          $display("FAIL rand_read[%0d] addr=%h: got valid=%b data=%h expected data=%h", it, a, rv, d, model_mem[a]);
        end
      end
    end
  endtask

  task automatic test_reset_mid_op();
    bit e_p, e_n, e_d, o_p, o_n, o_d, rv;
    int e_b, o_b, bad;
    logic [DATA_W-1:0] d, v;
    for (int i = 0; i < 4; i++) begin
      v = DATA_W'($urandom);
      model_cmd(OP_LOAD, ADDR_W'(i), v, 1'b0, e_p, e_n, e_b, e_d);
      run_cmd(OP_LOAD, ADDR_W'(i), v, 1'b0, 1'b0, '0, o_p, o_n, o_b, o_d, rv, d);
    end
    model_cmd(OP_WRITE, 14'h0140, '0, 1'b0, e_p, e_n, e_b, e_d);
    run_cmd(OP_WRITE, 14'h0140, '0, 1'b0, 1'b0, '0, o_p, o_n, o_b, o_d, rv, d);
    for (int i = 0; i < 8; i++) begin
      model_cmd(OP_LOAD, ADDR_W'(i), 16'h0000, 1'b0, e_p, e_n, e_b, e_d);
      run_cmd(OP_LOAD, ADDR_W'(i), 16'h0000, 1'b0, 1'b0, '0, o_p, o_n, o_b, o_d, rv, d);
    end
    cmd_valid = 1'b1; cmd_op = OP_WRITE; cmd_addr = 14'h0140;
    tick();
    cmd_valid = 1'b0;
    repeat (19) tick();
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL busy_at_cycle20: got %b expected 1", busy);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL async_abort: got busy=%b cmd_ready=%b expected 0 1", busy, cmd_ready);
    end
    #2;
    reset_n = 1'b1;
    model_clear_buf();
    tick();
    $display("reset mid-write: busy=%b cmd_ready=%b", busy, cmd_ready);
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      read_word(ADDR_W'('h0140 + i), d, rv);
      if (rv !== 1'b1 || d !== model_mem['h0140 + i]) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL abort_contents: got %0d changed words expected 0", bad);
    end
    model_cmd(OP_WRITE, 14'h0140, '0, 1'b0, e_p, e_n, e_b, e_d);
    run_cmd(OP_WRITE, 14'h0140, '0, 1'b0, 1'b0, '0, o_p, o_n, o_b, o_d, rv, d);
    checks++;
    if ({o_p, o_n, o_d} !== {e_p, e_n, e_d} || o_b != e_b) begin
      failures++;
      $display("FAIL abort_buffer_cleared: got prot/nobuf/done=%b busy=%0d expected %b busy=%0d", {o_p, o_n, o_d}, o_b, {e_p, e_n, e_d}, e_b);
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) model_mem[i] = 16'hFFFF;
    model_clear_buf();
    test_reset();
    test_read_basic();
    test_write();
    test_partial_write();
    test_erase();
    test_protect();
    test_busy_hold();
    test_random();
    test_reset_mid_op();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1, "watchdog expired");
  end

endmodule
